// File: rtl/dbus_uart_tx_if.sv
// CPU data-port bundle for the UART transmitter: same shape as the data RAM port.
// The CPU side (or bench) is master; the UART is slave.
interface dbus_uart_tx_if;
  logic        sel;
  logic [3:0]  wen;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output wen, output addr, output wdata, input rdata);
  modport slave  (input sel, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data port.
// Written bytes queue in a small FIFO and are shifted out at a programmable bit period.
module dbus_uart_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic           clk,
  input  logic           rst,
  dbus_uart_tx_if.slave  bus,
  output logic           tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_div;
  logic [15:0]   r_div_lat;
  logic [15:0]   r_cnt;
  logic [7:0]    r_sh;
  logic [2:0]    r_bit;
  state_t        r_state;
  logic          r_tx;
  logic [31:0]   r_rdata;

  logic          w_empty;
  logic          w_full;
  logic          w_busy;
  logic          w_wr_txdata;
  logic          w_clr_ovf;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [15:0]   w_div_eff;
  logic [7:0]    w_head;
  logic [31:0]   w_rd_val;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_busy      = (r_state != S_IDLE);
  assign w_wr_txdata = bus.sel && (bus.addr[1:0] == 2'd0) && bus.wen[0];
  assign w_clr_ovf   = bus.sel && (bus.addr[1:0] == 2'd1) && bus.wen[0] && bus.wdata[3];
  // The FSM takes a byte whenever it is idle or a stop bit just finished.
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && r_cnt == '0));
  assign w_push      = w_wr_txdata && (!w_full || w_pop);
  assign w_drop      = w_wr_txdata && w_full && !w_pop;
  assign w_div_eff   = (r_div == '0) ? 16'd1 : r_div;
  assign w_head      = r_mem[r_rd_ptr];

  // NOTE: storage holds no meaningful state until pushed, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= DIV_RESET;
    end else if (bus.sel && bus.addr[1:0] == 2'd2) begin
      if (bus.wen[0]) r_div[7:0]  <= bus.wdata[7:0];
      if (bus.wen[1]) r_div[15:8] <= bus.wdata[15:8];
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    w_rd_val = '0;
    case (bus.addr[1:0])
      2'd1:    w_rd_val = {16'b0, 8'(r_count), 4'b0, r_ovf, w_full, w_empty, w_busy};
      2'd2:    w_rd_val = {16'b0, r_div};
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= bus.sel ? w_rd_val : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_sh      <= '0;
      r_bit     <= '0;
      r_cnt     <= '0;
      r_div_lat <= 16'd1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_sh      <= w_head;
            r_div_lat <= w_div_eff;
            r_cnt     <= w_div_eff - 16'd1;
            r_tx      <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == '0) begin
            r_tx    <= r_sh[0];
            r_cnt   <= r_div_lat - 16'd1;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (r_cnt == '0) begin
            r_cnt <= r_div_lat - 16'd1;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              // r_sh[0] is always the bit currently on the line.
              r_tx  <= r_sh[1];
              r_sh  <= r_sh >> 1;
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (r_cnt == '0) begin
            if (w_pop) begin
              r_sh      <= w_head;
              r_div_lat <= w_div_eff;
              r_cnt     <= w_div_eff - 16'd1;
              r_tx      <= 1'b0;
              r_state   <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx        = r_tx;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Directed bench for dbus_uart_tx: register access, frame waveforms, FIFO overflow and reset.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_dbus_uart_tx;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  int   checks = 0;
  int   errors = 0;

  logic [31:0]  rv;
  logic [199:0] wave;
  logic [7:0]   b3 [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0]   b4 [2] = '{8'h3C, 8'hC3};

  dbus_uart_tx_if bus ();

  dbus_uart_tx #(
    .FIFO_DEPTH (4),
    .DIV_RESET  (16'd16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
    bus.sel   = 1'b1;
    bus.addr  = {20'd0, a};
    bus.wen   = w;
    bus.wdata = d;
  endtask

  task automatic idle_bus();
    bus.sel   = 1'b0;
    bus.addr  = '0;
    bus.wen   = '0;
    bus.wdata = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    drive(a, w, d);
    @(negedge clk);
    idle_bus();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    drive(a, 4'b0000, 32'h0);
    @(negedge clk);
    idle_bus();
    v = bus.rdata;
  endtask

  // Samples tx now and on the following n-1 falling edges, then steps one more edge.
  task automatic capture(input int n, output logic [199:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v[i] = tx;
      @(negedge clk);
    end
  endtask

  // Expected line level per cycle for one 8N1 frame: start, 8 data LSB first, stop.
  function automatic logic [199:0] frame_wave(input logic [7:0] b, input int d);
    logic [9:0]   f;
    logic [199:0] w;
    f = {1'b1, b, 1'b0};
    w = '0;
    for (int i = 0; i < 10 * d; i++) w[i] = f[i / d];
    return w;
  endfunction

  initial begin
    idle_bus();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdata", 200'(bus.rdata), 200'(32'h0));
    rst = 1'b0;

    // Reset state
    rd(2'd1, rv);
    check("rst_status", 200'(rv), 200'(32'h0000_0002));
    check("rst_tx", 200'(tx), 200'(1'b1));

    // Single frame at DIV=3
    wr(2'd2, 4'b0011, 32'd3);
    wr(2'd0, 4'b0001, 32'h0000_00A5);
    @(negedge clk);
    capture(30, wave);
    check("frame_a5_div3", wave, frame_wave(8'hA5, 3));
    rd(2'd1, rv);
    check("idle_after_a5", 200'(rv), 200'(32'h0000_0002));

    // Overflow: one byte popped at once, four queued, the sixth dropped.
    // Empty is clear while four bytes are queued, so status = count 4, ovf, full, busy.
    wr(2'd2, 4'b0011, 32'd100);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(2'd0, 4'b0001, {24'd0, b3[i]});
    end
    @(negedge clk);
    idle_bus();
    rd(2'd1, rv);
    check("ovf_status", 200'(rv), 200'(32'h0000_040D));
    wr(2'd1, 4'b0001, 32'h0000_0008);
    rd(2'd1, rv);
    check("ovf_cleared", 200'(rv), 200'(32'h0000_0405));

    // Reset mid data bit of byte 0x00 (line low), then a clean frame at reset DIV
    repeat (120) @(negedge clk);
    check("tx_low_in_data", 200'(tx), 200'(1'b0));
    #2 rst = 1'b1;
    #1 check("tx_async_rst", 200'(tx), 200'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    rd(2'd1, rv);
    check("status_after_rst", 200'(rv), 200'(32'h0000_0002));
    wr(2'd0, 4'b0001, 32'h0000_005A);
    @(negedge clk);
    capture(160, wave);
    check("frame_5a_div16", wave, frame_wave(8'h5A, 16));
    rd(2'd1, rv);
    check("idle_after_5a", 200'(rv), 200'(32'h0000_0002));

    // Back-to-back frames at DIV=2 with no idle gap
    wr(2'd2, 4'b0011, 32'd2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(2'd0, 4'b0001, {24'd0, b4[i]});
    end
    @(negedge clk);
    idle_bus();
    capture(40, wave);
    check("two_frames_div2", wave, frame_wave(8'h3C, 2) | (frame_wave(8'hC3, 2) << 20));
    check("tx_idle_after_two", 200'(tx), 200'(1'b1));
    rd(2'd1, rv);
    check("idle_after_two", 200'(rv), 200'(32'h0000_0002));

    // DIV byte lanes, read gating, DIV=0 behaving as 1
    wr(2'd2, 4'b0011, 32'h0000_1234);
    rd(2'd2, rv);
    check("div_1234", 200'(rv), 200'(32'h0000_1234));
    wr(2'd2, 4'b0001, 32'h0000_00FF);
    rd(2'd2, rv);
    check("div_12ff", 200'(rv), 200'(32'h0000_12FF));
    @(negedge clk);
    check("rdata_unselected", 200'(bus.rdata), 200'(32'h0));
    wr(2'd2, 4'b0011, 32'h0000_0000);
    wr(2'd0, 4'b0001, 32'h0000_0096);
    @(negedge clk);
    capture(10, wave);
    check("frame_96_div0", wave, frame_wave(8'h96, 1));
    wr(2'd3, 4'b1111, 32'hDEAD_BEEF);
    rd(2'd3, rv);
    check("reserved_reads_0", 200'(rv), 200'(32'h0));
    rd(2'd0, rv);
    check("txdata_reads_0", 200'(rv), 200'(32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
